// File: rtl/fractal_pixel_engine_pkg.sv
// Shared types and fixed-point helpers for the fractal pixel engine.
package fractal_pixel_engine_pkg;

  // Pixel engine control states.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_INIT = 2'd1,
    ST_ITER = 2'd2,
    ST_OUT  = 2'd3
  } fsm_state_t;

  // Bus response codes used by the surrounding register block.
  localparam logic [1:0] AXI_RESP_OK  = 2'b00;
  localparam logic [1:0] AXI_RESP_ERR = 2'b10;

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic int unsigned fp_one(input int unsigned frac_bits);
    return 32'd1 << frac_bits;
  endfunction

  // Squared escape radius (|z|^2 = 4.0) in the same fixed-point format.
  function automatic int unsigned fp_escape_radius_sq(input int unsigned frac_bits);
    return 32'd4 * fp_one(frac_bits);
  endfunction

endpackage

// File: rtl/fractal_iter_step.sv
// One z <- z^2 + c step with saturation, plus the escape test on the incoming z.
module fractal_iter_step
  import fractal_pixel_engine_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic signed [DATA_W-1:0] zr,
  input  logic signed [DATA_W-1:0] zi,
  input  logic signed [DATA_W-1:0] cr,
  input  logic signed [DATA_W-1:0] ci,
  output logic signed [DATA_W-1:0] zr_next_c,
  output logic signed [DATA_W-1:0] zi_next_c,
  output logic                     escape_c
);

  // Products and sums carried at 2*DATA_W+1 so squares, their sum and 2*zr*zi never overflow.
  localparam int unsigned EW = 2 * DATA_W + 1;

  localparam logic signed [EW-1:0] SAT_MAX = $signed({{(EW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [EW-1:0] SAT_MIN = $signed({{(EW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
  localparam logic signed [EW-1:0] ESC_LIM = $signed(EW'(fp_escape_radius_sq(FRAC_BITS)));

  function automatic logic signed [EW-1:0] ext(input logic signed [DATA_W-1:0] v);
    return {{(EW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end
    return v[DATA_W-1:0];
  endfunction

  logic signed [EW-1:0]     zr_e, zi_e, rr, ii, ri, mag;
  logic signed [DATA_W-1:0] re_part, im_part;

  // Squares, cross product, escape compare and the saturated update.
  always_comb begin
    zr_e      = ext(zr);
    zi_e      = ext(zi);
    rr        = zr_e * zr_e;
    ii        = zi_e * zi_e;
    ri        = zr_e * zi_e;
    mag       = rr + ii;
    escape_c  = (mag >>> FRAC_BITS) > ESC_LIM;
    re_part   = sat((rr - ii) >>> FRAC_BITS);
    im_part   = sat((ri <<< 1) >>> FRAC_BITS);
    zr_next_c = sat(ext(re_part) + ext(cr));
    zi_next_c = sat(ext(im_part) + ext(ci));
  end

endmodule

// File: rtl/fractal_pixel_engine.sv
// Raster-scan Mandelbrot/Julia escape-time engine, one pixel result per handshake.
module fractal_pixel_engine
  import fractal_pixel_engine_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ITER_W    = 8,
  parameter int unsigned X_SIZE    = 1280,
  parameter int unsigned Y_SIZE    = 960
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cfg_mode,
  input  logic [ITER_W-1:0] cfg_max_iter,
  input  logic [DATA_W-1:0] cfg_origin_re,
  input  logic [DATA_W-1:0] cfg_origin_im,
  input  logic [DATA_W-1:0] cfg_step_re,
  input  logic [DATA_W-1:0] cfg_step_im,
  input  logic [DATA_W-1:0] cfg_julia_re,
  input  logic [DATA_W-1:0] cfg_julia_im,
  output logic [ITER_W-1:0] pix_iter,
  output logic              pix_inside,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_valid,
  input  logic              pix_ready
);

  localparam int unsigned XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

  fsm_state_t state, state_next;

  // Per-frame shadow copy of the configuration.
  logic                     sh_mode;
  logic [ITER_W-1:0]        sh_max_iter;
  logic signed [DATA_W-1:0] sh_origin_re, sh_origin_im;
  logic signed [DATA_W-1:0] sh_step_re, sh_step_im;
  logic signed [DATA_W-1:0] sh_julia_re, sh_julia_im;

  logic signed [DATA_W-1:0] pt_re, pt_im;
  logic signed [DATA_W-1:0] zr, zi, cr, ci;
  logic signed [DATA_W-1:0] zr_next_c, zi_next_c;
  logic                     escape_c;
  logic [ITER_W-1:0]        count;
  logic [XW-1:0]            x;
  logic [YW-1:0]            y;

  logic [ITER_W-1:0]        eff_max_c;
  logic                     last_c, x_last_c, y_last_c, done_c;

  fractal_iter_step #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_step (
    .zr        (zr),
    .zi        (zi),
    .cr        (cr),
    .ci        (ci),
    .zr_next_c (zr_next_c),
    .zi_next_c (zi_next_c),
    .escape_c  (escape_c)
  );

  // Iteration limit (0 behaves as 1) and raster position decodes.
  always_comb begin
    eff_max_c = (sh_max_iter == '0) ? ITER_W'(1) : sh_max_iter;
    last_c    = ({1'b0, count} + (ITER_W+1)'(1)) == {1'b0, eff_max_c};
    x_last_c  = (x == XW'(X_SIZE - 1));
    y_last_c  = (y == YW'(Y_SIZE - 1));
    done_c    = escape_c || last_c;
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: state_next = ST_INIT;
      ST_INIT: state_next = ST_ITER;
      ST_ITER: if (done_c) state_next = ST_OUT;
      ST_OUT:  if (pix_ready) state_next = (x_last_c && y_last_c) ? ST_LOAD : ST_INIT;
      default: state_next = ST_LOAD;
    endcase
  end

  // Shadow config, coordinate accumulators, iteration datapath and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sh_mode      <= 1'b0;
      sh_max_iter  <= '0;
      sh_origin_re <= '0;
      sh_origin_im <= '0;
      sh_step_re   <= '0;
      sh_step_im   <= '0;
      sh_julia_re  <= '0;
      sh_julia_im  <= '0;
      pt_re        <= '0;
      pt_im        <= '0;
      zr           <= '0;
      zi           <= '0;
      cr           <= '0;
      ci           <= '0;
      count        <= '0;
      x            <= '0;
      y            <= '0;
      pix_iter     <= '0;
      pix_inside   <= 1'b0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      pix_valid    <= 1'b0;
    end else begin
      pix_valid <= (state_next == ST_OUT);
      case (state)
        ST_LOAD: begin
          sh_mode      <= cfg_mode;
          sh_max_iter  <= cfg_max_iter;
          sh_origin_re <= $signed(cfg_origin_re);
          sh_origin_im <= $signed(cfg_origin_im);
          sh_step_re   <= $signed(cfg_step_re);
          sh_step_im   <= $signed(cfg_step_im);
          sh_julia_re  <= $signed(cfg_julia_re);
          sh_julia_im  <= $signed(cfg_julia_im);
          pt_re        <= $signed(cfg_origin_re);
          pt_im        <= $signed(cfg_origin_im);
        end
        ST_INIT: begin
          count <= '0;
          if (sh_mode) begin
            zr <= pt_re;
            zi <= pt_im;
            cr <= sh_julia_re;
            ci <= sh_julia_im;
          end else begin
            zr <= '0;
            zi <= '0;
            cr <= pt_re;
            ci <= pt_im;
          end
        end
        ST_ITER: begin
          if (done_c) begin
            pix_iter   <= escape_c ? count : eff_max_c;
            pix_inside <= !escape_c;
            pix_sof    <= (x == '0) && (y == '0);
            pix_eol    <= x_last_c;
          end else begin
            zr    <= zr_next_c;
            zi    <= zi_next_c;
            count <= count + ITER_W'(1);
          end
        end
        ST_OUT: begin
          if (pix_ready) begin
            if (x_last_c) begin
              x     <= '0;
              pt_re <= sh_origin_re;
              if (y_last_c) begin
                y     <= '0;
                pt_im <= sh_origin_im;
              end else begin
                y     <= y + YW'(1);
                pt_im <= pt_im + sh_step_im;
              end
            end else begin
              x     <= x + XW'(1);
              pt_re <= pt_re + sh_step_re;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fractal_pixel_engine.sv
// Directed, table-driven bench for fractal_pixel_engine on a 4x2 frame.
module tb_fractal_pixel_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned FB = 8;
  localparam int unsigned IW = 8;
  localparam int unsigned XS = 4;
  localparam int unsigned YS = 2;
  localparam int          NPIX = XS * YS;
  localparam int          BUDGET = 4000;

  typedef struct {
    int mode;
    int max_iter;
    int org_re;
    int org_im;
    int step_re;
    int step_im;
    int jre;
    int jim;
  } cfg_t;

  typedef struct {
    string name;
    cfg_t  cfg;
    int    n;
    int    stall;
    bit    use_model;
    int    e_iter;
    int    e_ins;
  } vec_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cfg_mode;
  logic [IW-1:0] cfg_max_iter;
  logic [DW-1:0] cfg_origin_re, cfg_origin_im, cfg_step_re, cfg_step_im;
  logic [DW-1:0] cfg_julia_re, cfg_julia_im;
  logic [IW-1:0] pix_iter;
  logic          pix_inside, pix_sof, pix_eol, pix_valid;
  logic          pix_ready;

  int n_pass = 0;
  int n_total = 0;

  fractal_pixel_engine #(
    .DATA_W    (DW),
    .FRAC_BITS (FB),
    .ITER_W    (IW),
    .X_SIZE    (XS),
    .Y_SIZE    (YS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_mode      (cfg_mode),
    .cfg_max_iter  (cfg_max_iter),
    .cfg_origin_re (cfg_origin_re),
    .cfg_origin_im (cfg_origin_im),
    .cfg_step_re   (cfg_step_re),
    .cfg_step_im   (cfg_step_im),
    .cfg_julia_re  (cfg_julia_re),
    .cfg_julia_im  (cfg_julia_im),
    .pix_iter      (pix_iter),
    .pix_inside    (pix_inside),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Escape-time reference for pixel k of a frame (raster order).
  task automatic golden(input cfg_t c, input int k, output int it, output int ins);
    longint pr, pim, zr, zi, cr, ci, mag, nr, ni;
    int m;
    pr  = longint'(c.org_re) + longint'(k % XS) * longint'(c.step_re);
    pim = longint'(c.org_im) + longint'((k / XS) % YS) * longint'(c.step_im);
    if (c.mode != 0) begin
      zr = pr; zi = pim; cr = c.jre; ci = c.jim;
    end else begin
      zr = 0; zi = 0; cr = pr; ci = pim;
    end
    m = (c.max_iter == 0) ? 1 : c.max_iter;
    it = -1;
    ins = -1;
    for (int n = 0; n < 256; n++) begin
      mag = (zr * zr + zi * zi) >>> FB;
      if (mag > (4 << FB)) begin
        it = n; ins = 0; return;
      end
      if (n + 1 == m) begin
        it = m; ins = 1; return;
      end
      nr = sat32(sat32((zr * zr - zi * zi) >>> FB) + cr);
      ni = sat32(sat32((2 * zr * zi) >>> FB) + ci);
      zr = nr;
      zi = ni;
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    cfg_mode      = (c.mode != 0);
    cfg_max_iter  = IW'(c.max_iter);
    cfg_origin_re = DW'(c.org_re);
    cfg_origin_im = DW'(c.org_im);
    cfg_step_re   = DW'(c.step_re);
    cfg_step_im   = DW'(c.step_im);
    cfg_julia_re  = DW'(c.jre);
    cfg_julia_im  = DW'(c.jim);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Accept n pixels with random backpressure; check values, flags and stall stability.
  task automatic run_pixels(input string tag, input int n, input int stall,
                            input cfg_t c0, input cfg_t c1, input int change_at,
                            input bit use_model, input int e_iter, input int e_ins,
                            output int first_cyc, output int last_cyc);
    int k = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [IW+2:0] saved = '0;
    int it, ins;
    first_cyc = 0;
    last_cyc = 0;
    while (k < n && cyc < BUDGET) begin
      @(negedge aclk);
      cyc++;
      if (held) begin
        chk($sformatf("%s hold px%0d", tag, k),
            longint'({pix_valid, pix_iter, pix_inside, pix_sof, pix_eol}),
            longint'({1'b1, saved}));
      end
      pix_ready = ($urandom_range(99) >= stall);
      if (pix_valid && pix_ready) begin
        if (use_model) begin
          golden((k < NPIX) ? c0 : c1, k % NPIX, it, ins);
        end else begin
          it = e_iter;
          ins = e_ins;
        end
        chk($sformatf("%s px%0d iter", tag, k), longint'(pix_iter), longint'(it));
        chk($sformatf("%s px%0d inside", tag, k), longint'(pix_inside), longint'(ins));
        chk($sformatf("%s px%0d sof", tag, k), longint'(pix_sof), longint'(k % NPIX == 0));
        chk($sformatf("%s px%0d eol", tag, k), longint'(pix_eol), longint'(k % XS == XS - 1));
        if (k == 0) first_cyc = cyc;
        last_cyc = cyc;
        k++;
        if (k == change_at) apply_cfg(c1);
        held = 1'b0;
      end else if (pix_valid) begin
        held = 1'b1;
        saved = {pix_iter, pix_inside, pix_sof, pix_eol};
      end else begin
        held = 1'b0;
      end
    end
    chk($sformatf("%s pixel count", tag), longint'(k), longint'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    cfg_t c_in, c_esc, c_jul;
    int f, l, cyc;

    c_in  = '{mode: 0, max_iter: 20, org_re: 0, org_im: 0, step_re: 0, step_im: 0, jre: 0, jim: 0};
    c_esc = '{mode: 0, max_iter: 20, org_re: 768, org_im: 0, step_re: 0, step_im: 0, jre: 0, jim: 0};
    c_jul = '{mode: 1, max_iter: 50, org_re: -256, org_im: -128, step_re: 128, step_im: 128,
              jre: -213, jim: -59};

    vecs[0] = '{name: "mandel_inside", cfg: c_in, n: 8, stall: 0, use_model: 0, e_iter: 20, e_ins: 1};
    vecs[1] = '{name: "mandel_escape", cfg: c_esc, n: 8, stall: 0, use_model: 0, e_iter: 1, e_ins: 0};
    vecs[2] = '{name: "max_iter_zero",
                cfg: '{mode: 0, max_iter: 0, org_re: 0, org_im: 0, step_re: 0, step_im: 0, jre: 0, jim: 0},
                n: 8, stall: 0, use_model: 0, e_iter: 1, e_ins: 1};
    vecs[3] = '{name: "escape_at_limit",
                cfg: '{mode: 1, max_iter: 1, org_re: 768, org_im: 0, step_re: 0, step_im: 0, jre: 0, jim: 0},
                n: 8, stall: 0, use_model: 0, e_iter: 0, e_ins: 0};
    vecs[4] = '{name: "julia_2frames", cfg: c_jul, n: 16, stall: 30, use_model: 1, e_iter: 0, e_ins: 0};
    vecs[5] = '{name: "mandel_grid",
                cfg: '{mode: 0, max_iter: 30, org_re: -512, org_im: -256, step_re: 192, step_im: 256,
                       jre: 0, jim: 0},
                n: 8, stall: 20, use_model: 1, e_iter: 0, e_ins: 0};

    // Reset state.
    aresetn   = 1'b0;
    pix_ready = 1'b0;
    apply_cfg(c_in);
    #12;
    chk("reset valid", longint'(pix_valid), 0);
    chk("reset iter", longint'(pix_iter), 0);
    chk("reset inside", longint'(pix_inside), 0);
    chk("reset sof", longint'(pix_sof), 0);
    chk("reset eol", longint'(pix_eol), 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Table of frame-level vectors.
    for (int v = 0; v < 6; v++) begin
      apply_cfg(vecs[v].cfg);
      do_reset();
      run_pixels(vecs[v].name, vecs[v].n, vecs[v].stall, vecs[v].cfg, vecs[v].cfg, -1,
                 vecs[v].use_model, vecs[v].e_iter, vecs[v].e_ins, f, l);
    end

    // Zero-bubble throughput: INIT + 2 ITER + 1 OUT = 4 cycles per escaping pixel.
    apply_cfg(c_esc);
    do_reset();
    run_pixels("throughput", 8, 0, c_esc, c_esc, -1, 1'b0, 1, 0, f, l);
    chk("throughput cycles", longint'(l - f), 28);

    // Mid-frame origin change applies only from the next frame.
    apply_cfg(c_esc);
    do_reset();
    run_pixels("midframe_cfg", 16, 0, c_esc, c_in, 2, 1'b1, 0, 0, f, l);

    // Reset during ITER of pixel 5 abandons the frame and restarts at (0,0).
    apply_cfg(c_in);
    do_reset();
    run_pixels("pre_reset", 5, 0, c_in, c_in, -1, 1'b0, 20, 1, f, l);
    repeat (4) @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("midpixel rst valid", longint'(pix_valid), 0);
    chk("midpixel rst iter", longint'(pix_iter), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    run_pixels("post_reset", 8, 0, c_in, c_in, -1, 1'b0, 20, 1, f, l);

    // Reset while a result is presented drops pix_valid without a clock edge.
    pix_ready = 1'b0;
    cyc = 0;
    while (!pix_valid && cyc < 200) begin
      @(negedge aclk);
      cyc++;
    end
    chk("stalled valid seen", longint'(pix_valid), 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async valid drop", longint'(pix_valid), 0);
    chk("async sof drop", longint'(pix_sof), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    run_pixels("after_async", 1, 0, c_in, c_in, -1, 1'b0, 20, 1, f, l);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fractal_pixel_engine.md
FRACTAL_PIXEL_ENGINE -- requirements
Module: fractal_pixel_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed fixed-point width of all z/c values.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fractional bits (1.0 = 2^FRAC_BITS).
REQ-003 SHALL have parameter ITER_W, default 8: width of iteration counter and max_iter.
REQ-004 SHALL have parameters X_SIZE, default 1280, and Y_SIZE, default 960: frame dimensions in pixels.
REQ-005 SHALL have port aclk, input, 1: sole clock.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_mode, input, 1: 0 = Mandelbrot, 1 = Julia.
REQ-008 SHALL have port cfg_max_iter, input, ITER_W: iteration limit.
REQ-009 SHALL have ports cfg_origin_re and cfg_origin_im, input, DATA_W each: coordinate of pixel (0,0).
REQ-010 SHALL have ports cfg_step_re and cfg_step_im, input, DATA_W each: per-pixel increment along x and along y.
REQ-011 SHALL have ports cfg_julia_re and cfg_julia_im, input, DATA_W each: Julia constant c.
REQ-012 SHALL have port pix_iter, output, ITER_W: iteration count of the current pixel.
REQ-013 SHALL have port pix_inside, output, 1: 1 when max_iter was reached without escape.
REQ-014 SHALL have ports pix_sof and pix_eol, output, 1 each: pixel (0,0) flag and x == X_SIZE-1 flag.
REQ-015 SHALL have ports pix_valid, output, 1, and pix_ready, input, 1: output handshake.

Function
REQ-016 SHALL implement FSM states LOAD, INIT, ITER, OUT.
REQ-017 LOAD SHALL occur only at pixel (0,0), SHALL latch all cfg_* into shadow registers, and SHALL take 1 cycle before INIT; cfg_* changes mid-frame SHALL have no effect until the next frame.
REQ-018 INIT SHALL take 1 cycle: Mandelbrot z = 0, c = point; Julia z = point, c = julia constant; iteration count = 0.
REQ-019 The point SHALL be held in accumulators updated by addition only: +step_re per x advance; re reset to origin_re and +step_im per row; both reset to origin at frame wrap; no multiplier or divider on coordinates.
REQ-020 ITER SHALL perform one iteration per cycle: zr' = ((zr*zr - zi*zi) >>> FRAC_BITS) + cr, zi' = ((2*zr*zi) >>> FRAC_BITS) + ci.
REQ-021 Products SHALL be computed at 2*DATA_W, arithmetic-shifted, and saturated to DATA_W on truncation.
REQ-022 Escape test SHALL be (zr*zr + zi*zi) >>> FRAC_BITS > 4 << FRAC_BITS, evaluated on current z before update, with the sum at 2*DATA_W+1 bits (no overflow).
REQ-023 On escape, ITER→OUT with pix_iter = count, pix_inside = 0.
REQ-024 When count + 1 == max_iter without escape, ITER→OUT with pix_iter = max_iter, pix_inside = 1.
REQ-025 If escape and the limit coincide, escape SHALL take priority.
REQ-026 cfg_max_iter = 0 SHALL be treated as 1.
REQ-027 pix_valid SHALL be 1 only in OUT.
REQ-028 pix_iter, pix_inside, pix_sof and pix_eol SHALL be stable while pix_valid = 1 and pix_ready = 0.
REQ-029 On pix_valid & pix_ready, x/y SHALL advance: x wraps at X_SIZE-1, y increments; y wraps at Y_SIZE-1 with x wrap; next state SHALL be LOAD on frame wrap, else INIT.
REQ-030 Throughput SHALL be 1 cycle (INIT) + n iterations + ≥1 cycle (OUT) per pixel; zero-bubble acceptance when pix_ready is held high.

Reset
REQ-031 On aresetn low: state = LOAD, x = y = 0, pix_valid = 0, pix_iter = 0, pix_inside = 0, pix_sof = 0, pix_eol = 0, z/c/accumulators = 0.
REQ-032 Reset asserted mid-pixel or mid-frame SHALL abandon the pixel; the first pixel after release SHALL be (0,0) with pix_sof = 1.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the AXI OK/ERR response constants, and fixed-point helper constants (ONE, ESCAPE_RADIUS_SQ as functions of FRAC_BITS).
REQ-034 The iteration datapath (squares, cross-product, saturation, escape compare) SHALL be one sub-module, fractal_iter_step, purely combinational, instantiated once.
REQ-035 Config registers and colour mapping SHALL stay outside this block.

Verification
REQ-036 Mandelbrot, FRAC_BITS = 8, origin = (0,0), step = 0, max_iter = 20 → every pixel iter = 20, inside = 1.
REQ-037 Mandelbrot, origin = (3.0,0) = 0x300 → iteration 0 has z = 0; iteration 1 has |z|^2 = 9 > 4, so pix_iter = 1, inside = 0.
REQ-038 Julia, c = (-0.832,-0.23) = (-213,-59), X_SIZE = 4, Y_SIZE = 2 → 8 pixels match the golden model; pix_sof on pixel 0 only; pix_eol on pixels 3 and 7.
REQ-039 Random pix_ready backpressure, 30% low → outputs held constant while stalled; no pixel lost or duplicated across 2 frames.
REQ-040 Change cfg_origin_re mid-frame → remainder of the frame uses the old value; the next frame uses the new value.
REQ-041 aresetn pulsed low during ITER of pixel 5 → pix_valid drops asynchronously; the next output is pixel (0,0) with pix_sof = 1.
